// File: rtl/btb_assoc_if.sv
// Fetch-side bus of the set-associative BTB: lookup PC, stall, update port,
// flush request and the per-slot lookup results.
//
// Timing contract (there is no valid/ready pair on this bus):
//   - Every input is sampled on each rising clock edge. No input ever waits.
//   - A lookup is valid from the edge it is sampled on. That edge is the
//     last one with stall_i=0. Its result appears one cycle later.
//   - An update is taken when updateEn_i=1, the BTB is idle and btbFlush_i=0.
//     Otherwise it is silently dropped.
//   - busy_o=1 means a flush is sweeping the sets. Updates are dropped and
//     hits read 0 during that time.
interface btb_assoc_if #(
  parameter int FETCH_WIDTH = 4,
  parameter int PC_W        = 32,
  parameter int BT_W        = 2
);
  logic [PC_W-1:0]             PC_i;
  logic                        stall_i;
  logic                        updateEn_i;
  logic [PC_W-1:0]             updatePC_i;
  logic [PC_W-1:0]             updateTargetAddr_i;
  logic [BT_W-1:0]             updateBrType_i;
  logic                        btbFlush_i;
  logic [FETCH_WIDTH-1:0]      btbHit_o;
  logic [FETCH_WIDTH*PC_W-1:0] targetAddr_o;
  logic [FETCH_WIDTH*BT_W-1:0] ctrlType_o;
  logic                        busy_o;

  modport master (
    output PC_i, stall_i, updateEn_i, updatePC_i, updateTargetAddr_i,
           updateBrType_i, btbFlush_i,
    input  btbHit_o, targetAddr_o, ctrlType_o, busy_o
  );

  modport slave (
    input  PC_i, stall_i, updateEn_i, updatePC_i, updateTargetAddr_i,
           updateBrType_i, btbFlush_i,
    output btbHit_o, targetAddr_o, ctrlType_o, busy_o
  );
endinterface

// File: rtl/btb_assoc.sv
// Banked, set-associative branch target buffer. There is one bank per fetch
// slot, and each bank is read once per cycle. Lookups are registered.
// Writes are not bypassed to a lookup sampled on the same edge. A two-state
// FSM sweeps one set per cycle to invalidate the whole array.
module btb_assoc #(
  parameter int FETCH_WIDTH = 4,
  parameter int SETS        = 64,
  parameter int WAYS        = 2,
  parameter int PC_W        = 32,
  parameter int BYTE_OFF    = 3,
  parameter int BT_W        = 2
) (
  input  logic          clk,
  input  logic          reset,
  btb_assoc_if.slave    bus,
  output logic          dbg_state
);
  localparam int FBL      = $clog2(FETCH_WIDTH);
  localparam int BANK_W   = (FBL > 0) ? FBL : 1;
  localparam int SET_BITS = $clog2(SETS);
  localparam int SET_W    = (SET_BITS > 0) ? SET_BITS : 1;
  localparam int SET_LSB  = BYTE_OFF + FBL;
  localparam int TAG_LSB  = SET_LSB + SET_BITS;
  localparam int TAG_W    = PC_W - TAG_LSB;
  localparam int PTR_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [SET_W-1:0] LAST_SET = SET_W'(SETS - 1);
  localparam logic [PTR_W-1:0] LAST_WAY = PTR_W'(WAYS - 1);

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_e;

  function automatic logic [BANK_W-1:0] bank_of(input logic [PC_W-1:0] pc);
    logic [PC_W-1:0] sh;
    sh = pc >> BYTE_OFF;
    return (FBL == 0) ? '0 : sh[BANK_W-1:0];
  endfunction

  function automatic logic [SET_W-1:0] set_of(input logic [PC_W-1:0] pc);
    logic [PC_W-1:0] sh;
    sh = pc >> SET_LSB;
    return (SET_BITS == 0) ? '0 : sh[SET_W-1:0];
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [PC_W-1:0] pc);
    logic [PC_W-1:0] sh;
    sh = pc >> TAG_LSB;
    return sh[TAG_W-1:0];
  endfunction

  function automatic logic [BANK_W-1:0] wrap(input int v);
    return BANK_W'(v % FETCH_WIDTH);
  endfunction

  // Valid bits and pointers are reset. Tag and data storage is not.
  logic [WAYS-1:0]  valid_q  [FETCH_WIDTH][SETS];
  logic [PTR_W-1:0] ptr_q    [FETCH_WIDTH][SETS];
  logic [TAG_W-1:0] tag_mem  [FETCH_WIDTH][SETS][WAYS];
  logic [PC_W-1:0]  tgt_mem  [FETCH_WIDTH][SETS][WAYS];
  logic [BT_W-1:0]  type_mem [FETCH_WIDTH][SETS][WAYS];

  state_e           state_q, state_d;
  logic [SET_W-1:0] cnt_q, cnt_d;

  logic [PC_W-1:0]        slot_pc   [FETCH_WIDTH];
  logic [BANK_W-1:0]      bank0, src;
  logic [PC_W-1:0]        rd_pc;
  logic [SET_W-1:0]       rd_set;
  logic [TAG_W-1:0]       rd_tag;
  logic [FETCH_WIDTH-1:0] bank_hit;
  logic [PC_W-1:0]        bank_tgt  [FETCH_WIDTH];
  logic [BT_W-1:0]        bank_type [FETCH_WIDTH];
  logic [FETCH_WIDTH-1:0]      lk_hit, hit_q;
  logic [FETCH_WIDTH*PC_W-1:0] lk_tgt, tgt_q;
  logic [FETCH_WIDTH*BT_W-1:0] lk_type, type_q;

  logic [BANK_W-1:0] upd_bank;
  logic [SET_W-1:0]  upd_set;
  logic [TAG_W-1:0]  upd_tag;
  logic              match_hit, free_hit, wr_replace, upd_ok;
  logic [PTR_W-1:0]  match_way, free_way, wr_way;

  // Lookup: each bank reads the set of the slot rotated onto it. Results are
  // then rotated back into slot order.
  always_comb begin
    bank0 = bank_of(bus.PC_i);
    rd_pc = '0;
    rd_set = '0;
    rd_tag = '0;
    src = '0;
    bank_hit = '0;
    lk_hit = '0;
    lk_tgt = '0;
    lk_type = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      slot_pc[k] = bus.PC_i + (PC_W'(k) << BYTE_OFF);
    end
    for (int b = 0; b < FETCH_WIDTH; b++) begin
      rd_pc = slot_pc[wrap(b - int'(bank0) + FETCH_WIDTH)];
      rd_set = set_of(rd_pc);
      rd_tag = tag_of(rd_pc);
      bank_tgt[b] = '0;
      bank_type[b] = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
        if (valid_q[b][rd_set][w] && tag_mem[b][rd_set][w] == rd_tag) begin
          bank_hit[b] = 1'b1;
          bank_tgt[b] = tgt_mem[b][rd_set][w];
          bank_type[b] = type_mem[b][rd_set][w];
        end
      end
    end
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      src = wrap(int'(bank0) + k);
      lk_hit[k] = bank_hit[src];
      lk_tgt[k*PC_W +: PC_W] = bank_tgt[src];
      lk_type[k*BT_W +: BT_W] = bank_type[src];
    end
  end

  // Update way choice: overwrite a tag match, else the lowest invalid way,
  // else the round-robin victim.
  always_comb begin
    upd_bank = bank_of(bus.updatePC_i);
    upd_set = set_of(bus.updatePC_i);
    upd_tag = tag_of(bus.updatePC_i);
    match_hit = 1'b0;
    match_way = '0;
    free_hit = 1'b0;
    free_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[upd_bank][upd_set][w] && tag_mem[upd_bank][upd_set][w] == upd_tag) begin
        match_hit = 1'b1;
        match_way = PTR_W'(w);
      end
      if (!valid_q[upd_bank][upd_set][w]) begin
        free_hit = 1'b1;
        free_way = PTR_W'(w);
      end
    end
    wr_replace = !match_hit && !free_hit;
    wr_way = match_hit ? match_way : (free_hit ? free_way : ptr_q[upd_bank][upd_set]);
    upd_ok = bus.updateEn_i && (state_q == IDLE) && !bus.btbFlush_i;
  end

  // Flush FSM next state: a request in FLUSH is ignored. The sweep ends
  // after the last set.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.btbFlush_i) begin
          state_d = FLUSH;
          cnt_d = '0;
        end
      end
      FLUSH: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_SET) begin
          state_d = IDLE;
          cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, valid bits and replacement pointers. Reset beats flush, and flush
  // beats update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      for (int b = 0; b < FETCH_WIDTH; b++) begin
        for (int s = 0; s < SETS; s++) begin
          valid_q[b][s] <= '0;
          ptr_q[b][s] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (state_q == FLUSH) begin
        for (int b = 0; b < FETCH_WIDTH; b++) begin
          valid_q[b][cnt_q] <= '0;
          ptr_q[b][cnt_q] <= '0;
        end
      end else if (upd_ok) begin
        valid_q[upd_bank][upd_set][wr_way] <= 1'b1;
        if (wr_replace) begin
          ptr_q[upd_bank][upd_set] <= (ptr_q[upd_bank][upd_set] == LAST_WAY) ?
                                      '0 : ptr_q[upd_bank][upd_set] + 1'b1;
        end
      end
    end
  end

  // Tag and data storage write. Contents only matter once the way is valid.
  always_ff @(posedge clk) begin
    if (upd_ok && !reset) begin
      tag_mem[upd_bank][upd_set][wr_way] <= upd_tag;
      tgt_mem[upd_bank][upd_set][wr_way] <= bus.updateTargetAddr_i;
      type_mem[upd_bank][upd_set][wr_way] <= bus.updateBrType_i;
    end
  end

  // Lookup result register: cleared on the flush entry edge and throughout
  // the flush, held under stall.
  always_ff @(posedge clk) begin
    if (reset || state_q == FLUSH || bus.btbFlush_i) begin
      hit_q <= '0;
      tgt_q <= '0;
      type_q <= '0;
    end else if (!bus.stall_i) begin
      hit_q <= lk_hit;
      tgt_q <= lk_tgt;
      type_q <= lk_type;
    end
  end

  assign bus.btbHit_o = hit_q;
  assign bus.targetAddr_o = tgt_q;
  assign bus.ctrlType_o = type_q;
  assign bus.busy_o = (state_q == FLUSH);
  assign dbg_state = state_q;
endmodule

// File: tb/tb_btb_assoc.sv
// Testbench for btb_assoc. A table of lookup vectors and hand-written
// sequences covers replacement, same-edge write/read, stall, flush and
// reset during a flush.
module tb_btb_assoc;
  localparam int FW = 4;
  localparam int PC_W = 32;
  localparam int BT_W = 2;
  localparam int OW = FW + FW * PC_W + FW * BT_W;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [OW-1:0]   exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic dbg_state;
  logic [OW-1:0] exp_q[$];
  int n_pass = 0;
  int n_total = 0;
  int busy_cycles;
  int bad_hits;
  vec_t tbl [6];

  btb_assoc_if #(.FETCH_WIDTH(FW), .PC_W(PC_W), .BT_W(BT_W)) bus ();

  btb_assoc #(
    .FETCH_WIDTH(FW), .SETS(64), .WAYS(2), .PC_W(PC_W), .BYTE_OFF(3), .BT_W(BT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  function automatic logic [OW-1:0] mk(input logic [3:0] hit,
                                       input logic [31:0] t0, t1, t2, t3,
                                       input logic [1:0] y0, y1, y2, y3);
    return {hit, t3, t2, t1, t0, y3, y2, y1, y0};
  endfunction

  function automatic logic [OW-1:0] dut_out();
    return {bus.btbHit_o, bus.targetAddr_o, bus.ctrlType_o};
  endfunction

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic compare(input string name);
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL %s: got output with empty scoreboard, expected a queued entry", name);
    end else begin
      check(name, dut_out(), exp_q.pop_front());
    end
  endtask

  task automatic do_update(input logic [31:0] pc, input logic [31:0] tgt, input logic [1:0] ty);
    bus.updatePC_i = pc;
    bus.updateTargetAddr_i = tgt;
    bus.updateBrType_i = ty;
    bus.updateEn_i = 1'b1;
    tick();
    bus.updateEn_i = 1'b0;
  endtask

  task automatic lookup(input string name, input logic [31:0] pc, input logic [OW-1:0] exp);
    bus.PC_i = pc;
    exp_q.push_back(exp);
    tick();
    compare(name);
  endtask

  initial begin
    bus.PC_i = '0;
    bus.stall_i = 1'b0;
    bus.updateEn_i = 1'b0;
    bus.updatePC_i = '0;
    bus.updateTargetAddr_i = '0;
    bus.updateBrType_i = '0;
    bus.btbFlush_i = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    check("reset_out", dut_out(), '0);
    check("reset_busy", OW'(bus.busy_o), '0);
    reset = 1'b0;

    // Basic hit and rotation
    do_update(32'h1008, 32'h2000, 2'd1);
    lookup("basic_hit", 32'h1000, mk(4'b0010, 0, 32'h2000, 0, 0, 0, 1, 0, 0));
    lookup("rotation", 32'h1008, mk(4'b0001, 32'h2000, 0, 0, 0, 1, 0, 0, 0));

    // More entries across banks and sets, then the vector table
    do_update(32'h4010, 32'h5550, 2'd2);
    do_update(32'h1018, 32'h3330, 2'd3);
    do_update(32'h1020, 32'h7000, 2'd0);
    do_update(32'h0000, 32'h1234, 2'd1);
    tbl[0] = '{pc: 32'h1000, exp: mk(4'b1010, 0, 32'h2000, 0, 32'h3330, 0, 1, 0, 3)};
    tbl[1] = '{pc: 32'h1008, exp: mk(4'b1101, 32'h2000, 0, 32'h3330, 32'h7000, 1, 0, 3, 0)};
    tbl[2] = '{pc: 32'h4010, exp: mk(4'b0001, 32'h5550, 0, 0, 0, 2, 0, 0, 0)};
    tbl[3] = '{pc: 32'h2000, exp: '0};
    tbl[4] = '{pc: 32'hFFFF_FFF8, exp: mk(4'b0010, 0, 32'h1234, 0, 0, 0, 1, 0, 0)};
    tbl[5] = '{pc: 32'h0000, exp: mk(4'b0001, 32'h1234, 0, 0, 0, 1, 0, 0, 0)};
    for (int i = 0; i < 6; i++) lookup($sformatf("vec%0d", i), tbl[i].pc, tbl[i].exp);

    // Replacement in bank 1 / set 0: overwrite, fill, replace way 0, replace way 1
    do_update(32'h1008, 32'hA000, 2'd1);
    do_update(32'h1808, 32'hB000, 2'd2);
    do_update(32'h2008, 32'hC000, 2'd3);
    lookup("repl_1808", 32'h1808, mk(4'b0001, 32'hB000, 0, 0, 0, 2, 0, 0, 0));
    lookup("repl_2008", 32'h2008, mk(4'b0001, 32'hC000, 0, 0, 0, 3, 0, 0, 0));
    lookup("repl_evict", 32'h1008, mk(4'b1100, 0, 0, 32'h3330, 32'h7000, 0, 0, 3, 0));
    do_update(32'h2808, 32'hE000, 2'd1);
    lookup("ptr_2808", 32'h2808, mk(4'b0001, 32'hE000, 0, 0, 0, 1, 0, 0, 0));
    lookup("ptr_2008", 32'h2008, mk(4'b0001, 32'hC000, 0, 0, 0, 3, 0, 0, 0));
    lookup("ptr_1808", 32'h1808, '0);

    // Same-edge write and read
    bus.updatePC_i = 32'h3000;
    bus.updateTargetAddr_i = 32'hD000;
    bus.updateBrType_i = 2'd2;
    bus.updateEn_i = 1'b1;
    lookup("same_edge_miss", 32'h3000, '0);
    bus.updateEn_i = 1'b0;
    lookup("same_edge_next", 32'h3000, mk(4'b0001, 32'hD000, 0, 0, 0, 2, 0, 0, 0));

    // Stall holds the result while PC changes
    lookup("pre_stall", 32'h1000, mk(4'b1000, 0, 0, 0, 32'h3330, 0, 0, 0, 3));
    bus.stall_i = 1'b1;
    lookup("stall_hold0", 32'h4010, mk(4'b1000, 0, 0, 0, 32'h3330, 0, 0, 0, 3));
    lookup("stall_hold1", 32'h0000, mk(4'b1000, 0, 0, 0, 32'h3330, 0, 0, 0, 3));
    lookup("stall_hold2", 32'h3000, mk(4'b1000, 0, 0, 0, 32'h3330, 0, 0, 0, 3));
    bus.stall_i = 1'b0;
    lookup("stall_release", 32'h4010, mk(4'b0001, 32'h5550, 0, 0, 0, 2, 0, 0, 0));

    // Flush with a same-edge update and a repeated request mid-flush
    bus.PC_i = 32'h1000;
    bus.btbFlush_i = 1'b1;
    bus.updatePC_i = 32'h6000;
    bus.updateTargetAddr_i = 32'hF000;
    bus.updateBrType_i = 2'd2;
    bus.updateEn_i = 1'b1;
    tick();
    bus.btbFlush_i = 1'b0;
    bus.updateEn_i = 1'b0;
    busy_cycles = 0;
    bad_hits = 0;
    for (int c = 0; c < 200; c++) begin
      if (!bus.busy_o) break;
      busy_cycles++;
      if (bus.btbHit_o != '0) bad_hits++;
      bus.btbFlush_i = (c == 5);
      tick();
    end
    bus.btbFlush_i = 1'b0;
    check("flush_len", OW'(busy_cycles), OW'(64));
    check("flush_hits", OW'(bad_hits), '0);
    check("flush_exit_out", dut_out(), '0);
    lookup("post_flush_1000", 32'h1000, '0);
    lookup("post_flush_1008", 32'h1008, '0);
    lookup("post_flush_4010", 32'h4010, '0);
    lookup("post_flush_0000", 32'h0000, '0);
    lookup("post_flush_3000", 32'h3000, '0);
    lookup("post_flush_6000", 32'h6000, '0);
    do_update(32'h6000, 32'hF000, 2'd2);
    lookup("after_flush_update", 32'h6000, mk(4'b0001, 32'hF000, 0, 0, 0, 2, 0, 0, 0));

    // Reset at flush cycle 10 with an entry in a set not yet swept
    do_update(32'h0508, 32'h9000, 2'd1);
    lookup("high_set_hit", 32'h0508, mk(4'b0001, 32'h9000, 0, 0, 0, 1, 0, 0, 0));
    bus.btbFlush_i = 1'b1;
    tick();
    bus.btbFlush_i = 1'b0;
    repeat (10) tick();
    check("mid_flush_busy", OW'(bus.busy_o), OW'(1));
    reset = 1'b1;
    tick();
    check("reset_flush_busy", OW'(bus.busy_o), '0);
    check("reset_flush_out", dut_out(), '0);
    reset = 1'b0;
    lookup("reset_flush_miss", 32'h0508, '0);
    check("post_reset_idle", OW'(bus.busy_o), '0);
    do_update(32'h0508, 32'h9100, 2'd3);
    lookup("post_reset_update", 32'h0508, mk(4'b0001, 32'h9100, 0, 0, 0, 3, 0, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
